// File: rtl/iir_biquad_seq.sv
// Direct-form-I biquad for one equalizer band: five MACs per sample on one shared multiplier.
// Define IIR_ROUND_EN to round half up before the output shift instead of truncating.
module iir_biquad_seq #(
    parameter int p     = 4,
    parameter int f     = 13,
    parameter int Width = 1 + p + f
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [Width-1:0] xk,
    input  logic             x_valid,
    input  logic             flush,
    input  logic [Width-1:0] b0,
    input  logic [Width-1:0] b1,
    input  logic [Width-1:0] b2,
    input  logic [Width-1:0] a1,
    input  logic [Width-1:0] a2,
    output logic [Width-1:0] yk,
    output logic             yk_valid,
    output logic             busy,
    output logic             overrun
);

    localparam int PW = 2 * Width;
    localparam int AW = 2 * Width + 3;

    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-Width+1){1'b0}}, {(Width-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-Width+1){1'b1}}, {(Width-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, MAC0, MAC1, MAC2, MAC3, MAC4, SAT} state_t;

    state_t state, next_state;

    logic signed [Width-1:0] x0, x1, x2, y1, y2;
    logic signed [Width-1:0] c_b0, c_b1, c_b2, c_a1, c_a2;
    logic signed [Width-1:0] mul_coef, mul_data, sat_val;
    logic signed [PW-1:0]    product;
    logic signed [AW-1:0]    product_ext, acc, acc_adj, shifted;
    logic                    subtract;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (x_valid) next_state = MAC0;
            MAC0:    next_state = MAC1;
            MAC1:    next_state = MAC2;
            MAC2:    next_state = MAC3;
            MAC3:    next_state = MAC4;
            MAC4:    next_state = SAT;
            SAT:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Feedback terms are subtracted so a1/a2 keep the textbook sign convention.
    always_comb begin
        mul_coef = c_b0;
        mul_data = x0;
        subtract = 1'b0;
        case (state)
            MAC1: begin mul_coef = c_b1; mul_data = x1; end
            MAC2: begin mul_coef = c_b2; mul_data = x2; end
            MAC3: begin mul_coef = c_a1; mul_data = y1; subtract = 1'b1; end
            MAC4: begin mul_coef = c_a2; mul_data = y2; subtract = 1'b1; end
            default: ;
        endcase
    end

    assign product     = $signed({{Width{mul_coef[Width-1]}}, mul_coef})
                       * $signed({{Width{mul_data[Width-1]}}, mul_data});
    assign product_ext = {{(AW-PW){product[PW-1]}}, product};

`ifdef IIR_ROUND_EN
    localparam logic signed [AW-1:0] ROUND_ADD = {{(AW-f){1'b0}}, 1'b1, {(f-1){1'b0}}};
    assign acc_adj = acc + ROUND_ADD;
`else
    assign acc_adj = acc;
`endif

    assign shifted = acc_adj >>> f;

    always_comb begin
        if (shifted > SAT_MAX)      sat_val = SAT_MAX[Width-1:0];
        else if (shifted < SAT_MIN) sat_val = SAT_MIN[Width-1:0];
        else                        sat_val = shifted[Width-1:0];
    end

    // Flush is evaluated before the sample latch, so a simultaneous sample sees zero history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x0 <= '0; x1 <= '0; x2 <= '0; y1 <= '0; y2 <= '0;
            c_b0 <= '0; c_b1 <= '0; c_b2 <= '0; c_a1 <= '0; c_a2 <= '0;
            acc      <= '0;
            yk       <= '0;
            yk_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            yk_valid <= 1'b0;
            overrun  <= x_valid && (state != IDLE);
            case (state)
                IDLE: begin
                    if (flush) begin
                        x1 <= '0; x2 <= '0; y1 <= '0; y2 <= '0;
                    end
                    if (x_valid) begin
                        x0   <= xk;
                        c_b0 <= b0; c_b1 <= b1; c_b2 <= b2;
                        c_a1 <= a1; c_a2 <= a2;
                        acc  <= '0;
                    end
                end
                MAC0, MAC1, MAC2, MAC3, MAC4:
                    acc <= subtract ? acc - product_ext : acc + product_ext;
                SAT: begin
                    yk       <= sat_val;
                    yk_valid <= 1'b1;
                    x2 <= x1; x1 <= x0;
                    y2 <= y1; y1 <= sat_val;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_iir_biquad_seq.sv
// Self-checking bench for iir_biquad_seq: directed vector table, corner sequences,
// and randomized samples against an arithmetic reference of the biquad equation.
module tb_iir_biquad_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [17:0] xk, b0, b1, b2, a1, a2;
    logic        x_valid, flush;
    logic [17:0] yk;
    logic        yk_valid, busy, overrun;

    int checks = 0;
    int errors = 0;

    longint mx1, mx2, my1, my2;

    typedef struct {
        logic [17:0] x;
        logic [17:0] cb0, cb1, cb2, ca1, ca2;
        logic        fl;
        logic [17:0] exp_y;
    } vec_t;

    vec_t tbl[10];

`ifdef IIR_ROUND_EN
    localparam logic [17:0] RND_POS = 18'h00001;
    localparam logic [17:0] RND_NEG = 18'h00000;
`else
    localparam logic [17:0] RND_POS = 18'h00000;
    localparam logic [17:0] RND_NEG = 18'h3FFFF;
`endif

    iir_biquad_seq dut (
        .clk(clk), .rst_n(rst_n), .xk(xk), .x_valid(x_valid), .flush(flush),
        .b0(b0), .b1(b1), .b2(b2), .a1(a1), .a2(a2),
        .yk(yk), .yk_valid(yk_valid), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic longint s18(input logic [17:0] v);
        return longint'($signed(v));
    endfunction

    function automatic logic [17:0] quantize(input longint acc);
        longint r;
        r = acc;
`ifdef IIR_ROUND_EN
        r = r + 4096;
`endif
        r = r >>> 13;
        if (r > 131071)       r = 131071;
        else if (r < -131072) r = -131072;
        return r[17:0];
    endfunction

    // Reference: evaluate the difference equation directly on integer history.
    function automatic logic [17:0] model_step(input logic [17:0] x, cb0, cb1, cb2, ca1, ca2,
                                               input logic do_flush);
        longint acc;
        logic [17:0] y;
        if (do_flush) begin
            mx1 = 0; mx2 = 0; my1 = 0; my2 = 0;
        end
        acc = s18(cb0) * s18(x) + s18(cb1) * mx1 + s18(cb2) * mx2
            - s18(ca1) * my1 - s18(ca2) * my2;
        y   = quantize(acc);
        mx2 = mx1; mx1 = s18(x);
        my2 = my1; my1 = s18(y);
        return y;
    endfunction

    function automatic logic [17:0] rnd_val();
        int v;
        if ($urandom_range(0, 3) == 0) return 18'($urandom);
        v = int'($urandom_range(0, 16384)) - 8192;
        return 18'(v);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Issue one sample, scramble inputs while busy (they must not matter), wait for the result.
    task automatic applyStimulus(input logic [17:0] x, cb0, cb1, cb2, ca1, ca2,
                                 input logic do_flush,
                                 output logic [17:0] y_out, output int lat);
        @(negedge clk);
        xk = x; b0 = cb0; b1 = cb1; b2 = cb2; a1 = ca1; a2 = ca2;
        flush = do_flush; x_valid = 1'b1;
        @(posedge clk); #1;
        x_valid = 1'b0;
        flush = 1'($urandom_range(0, 1));
        xk = rnd_val(); b0 = rnd_val(); b1 = rnd_val(); b2 = rnd_val();
        a1 = rnd_val(); a2 = rnd_val();
        lat = 0;
        y_out = '0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (c >= 4) flush = 1'b0;
            if (yk_valid) begin
                lat = c;
                y_out = yk;
                break;
            end
        end
        flush = 1'b0;
    endtask

    initial begin
        logic [17:0] y, e, exp1;
        int lat, nvalid;

        tbl[0] = '{18'h00C00, 18'h02000, 18'h0, 18'h0, 18'h0, 18'h0, 1'b0, 18'h00C00};
        tbl[1] = '{18'h3F400, 18'h02000, 18'h0, 18'h0, 18'h0, 18'h0, 1'b0, 18'h3F400};
        tbl[2] = '{18'h1FFFF, 18'h04000, 18'h0, 18'h0, 18'h0, 18'h0, 1'b0, 18'h1FFFF};
        tbl[3] = '{18'h20000, 18'h04000, 18'h0, 18'h0, 18'h0, 18'h0, 1'b0, 18'h20000};
        tbl[4] = '{18'h00001, 18'h01000, 18'h0, 18'h0, 18'h0, 18'h0, 1'b0, RND_POS};
        tbl[5] = '{18'h3FFFF, 18'h01000, 18'h0, 18'h0, 18'h0, 18'h0, 1'b0, RND_NEG};
        tbl[6] = '{18'h02000, 18'h02000, 18'h0, 18'h0, 18'h3F000, 18'h0, 1'b1, 18'h02000};
        tbl[7] = '{18'h00000, 18'h02000, 18'h0, 18'h0, 18'h3F000, 18'h0, 1'b0, 18'h01000};
        tbl[8] = '{18'h00000, 18'h02000, 18'h0, 18'h0, 18'h3F000, 18'h0, 1'b0, 18'h00800};
        tbl[9] = '{18'h00000, 18'h02000, 18'h0, 18'h0, 18'h3F000, 18'h0, 1'b0, 18'h00400};

        mx1 = 0; mx2 = 0; my1 = 0; my2 = 0;
        rst_n = 1'b0; x_valid = 1'b0; flush = 1'b0;
        xk = '0; b0 = '0; b1 = '0; b2 = '0; a1 = '0; a2 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("reset_yk", yk, 0);
        checkOutput("reset_yk_valid", yk_valid, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_overrun", overrun, 0);

        $display("[TB] directed vector table");
        for (int i = 0; i < 10; i++) begin
            e = model_step(tbl[i].x, tbl[i].cb0, tbl[i].cb1, tbl[i].cb2, tbl[i].ca1, tbl[i].ca2, tbl[i].fl);
            applyStimulus(tbl[i].x, tbl[i].cb0, tbl[i].cb1, tbl[i].cb2, tbl[i].ca1, tbl[i].ca2,
                          tbl[i].fl, y, lat);
            checkOutput($sformatf("table_y[%0d]", i), y, tbl[i].exp_y);
            checkOutput($sformatf("table_latency[%0d]", i), lat, 6);
        end

        $display("[TB] flush alone in idle");
        @(negedge clk) flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        mx1 = 0; mx2 = 0; my1 = 0; my2 = 0;
        checkOutput("flush_holds_yk", yk, 18'h00400);
        e = model_step(18'h0, 18'h02000, 18'h0, 18'h0, 18'h3F000, 18'h0, 1'b0);
        applyStimulus(18'h0, 18'h02000, 18'h0, 18'h0, 18'h3F000, 18'h0, 1'b0, y, lat);
        checkOutput("flush_zero_y", y, 18'h0);
        checkOutput("flush_model_y", y, e);

        $display("[TB] overrun sequence");
        @(negedge clk);
        xk = 18'h00400; b0 = 18'h02000; b1 = 18'h02000; b2 = '0; a1 = '0; a2 = '0;
        flush = 1'b1; x_valid = 1'b1;
        exp1 = model_step(18'h00400, 18'h02000, 18'h02000, 18'h0, 18'h0, 18'h0, 1'b1);
        @(posedge clk); #1;
        x_valid = 1'b0; flush = 1'b0;
        nvalid = 0;
        y = '0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c == 3) begin
                xk = 18'h01000; x_valid = 1'b1;
            end else begin
                x_valid = 1'b0;
            end
            @(posedge clk); #1;
            checkOutput($sformatf("overrun_pulse[%0d]", c), overrun, (c == 3));
            if (yk_valid) begin
                nvalid++;
                y = yk;
                checkOutput("overrun_valid_cycle", c, 6);
            end
        end
        x_valid = 1'b0;
        checkOutput("overrun_valid_count", nvalid, 1);
        checkOutput("overrun_y", y, exp1);
        e = model_step(18'h0, 18'h02000, 18'h02000, 18'h0, 18'h0, 18'h0, 1'b0);
        applyStimulus(18'h0, 18'h02000, 18'h02000, 18'h0, 18'h0, 18'h0, 1'b0, y, lat);
        checkOutput("overrun_history_y", y, e);
        checkOutput("overrun_history_const", y, 18'h00400);

        $display("[TB] reset during MAC2");
        @(negedge clk);
        xk = 18'h01234; b0 = 18'h02000; b1 = '0; b2 = '0; a1 = '0; a2 = '0;
        x_valid = 1'b1;
        @(posedge clk); #1;
        x_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        checkOutput("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_yk", yk, 0);
        checkOutput("midreset_yk_valid", yk_valid, 0);
        checkOutput("midreset_busy", busy, 0);
        checkOutput("midreset_overrun", overrun, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        mx1 = 0; mx2 = 0; my1 = 0; my2 = 0;
        nvalid = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (yk_valid) nvalid++;
        end
        checkOutput("midreset_no_valid", nvalid, 0);
        checkOutput("midreset_idle", busy, 0);

        $display("[TB] randomized samples");
        for (int i = 0; i < 40; i++) begin
            logic [17:0] rx, r0, r1, r2, r3, r4;
            logic rf;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            rx = rnd_val(); r0 = rnd_val(); r1 = rnd_val(); r2 = rnd_val();
            r3 = rnd_val(); r4 = rnd_val();
            rf = ($urandom_range(0, 4) == 0);
            e = model_step(rx, r0, r1, r2, r3, r4, rf);
            applyStimulus(rx, r0, r1, r2, r3, r4, rf, y, lat);
            checkOutput($sformatf("random_y[%0d]", i), y, e);
            checkOutput($sformatf("random_latency[%0d]", i), lat, 6);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
